// File: rtl/wm8731_cfg_pkg.sv
// Shared types and helpers for the WM8731 runtime configuration arbiter.
package wm8731_cfg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StGo,
      StCheck,
      StGap
   } state_e;

   typedef enum logic [6:0] {
      RegLinL    = 7'h00,
      RegRinL    = 7'h01,
      RegLhpOut  = 7'h02,
      RegRhpOut  = 7'h03,
      RegAnaPath = 7'h04,
      RegDigPath = 7'h05,
      RegPower   = 7'h06,
      RegDaif    = 7'h07,
      RegSample  = 7'h08,
      RegActive  = 7'h09,
      RegReset   = 7'h0F
   } wm_reg_e;

   function automatic logic [15:0] build_word(input logic [6:0] reg_addr, input logic [8:0] value);
      return {reg_addr, value};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IW'((32'(ptr_i) + k) % N);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/wm8731_cfg_arbiter.sv
// Shares one codec I2C write controller between N_REQ runtime requesters:
// round-robin grant, one write in flight, bounded NACK retry, GO watchdog.
module wm8731_cfg_arbiter
   import wm8731_cfg_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter logic [7:0]  SLAVE_ADDR     = 8'h34,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [16*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      req_done,
   output logic [N_REQ-1:0]      req_err,
   output logic                  busy,
   output logic [23:0]           i2c_data,
   output logic                  i2c_go,
   input  logic                  i2c_end,
   input  logic                  i2c_ack
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_e        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] win_q, win_d;
   logic [23:0]   word_q, word_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          pend_q, pend_d;
   logic          nack_q, nack_d;
   logic          tmo_q, tmo_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] tcnt_q, tcnt_d;

   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic [15:0]      slice;
   logic             can_retry;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_rr (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   always_comb begin
      slice = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_q == IW'(i)) slice = req_data[16*i +: 16];
      end
   end

   assign can_retry = !tmo_q && nack_q && (32'(retry_q) < MAX_RETRY);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      word_d    = word_q;
      retry_d   = retry_q;
      pend_d    = pend_q;
      nack_d    = nack_q;
      tmo_d     = tmo_q;
      gap_d     = gap_q;
      tcnt_d    = tcnt_q;
      req_ready = '0;
      req_done  = '0;
      req_err   = '0;

      unique case (state_q)
         StIdle: begin
            if (|gnt) begin
               win_d   = gnt_idx;
               state_d = StLoad;
            end
         end
         StLoad: begin
            req_ready[win_q] = 1'b1;
            word_d  = {SLAVE_ADDR, slice};
            retry_d = '0;
            tcnt_d  = '0;
            ptr_d   = (32'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
            state_d = StGo;
         end
         StGo: begin
            if (i2c_end) begin
               nack_d  = i2c_ack;
               tmo_d   = 1'b0;
               state_d = StCheck;
            end else if (32'(tcnt_q) + 32'd1 >= TIMEOUT_CYCLES) begin
               tmo_d   = 1'b1;
               state_d = StCheck;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         StCheck: begin
            if (!tmo_q && !nack_q) begin
               req_done[win_q] = 1'b1;
            end else if (!can_retry) begin
               req_err[win_q] = 1'b1;
            end
            if (can_retry) retry_d = retry_q + 1'b1;
            pend_d  = can_retry;
            gap_d   = '0;
            state_d = StGap;
         end
         StGap: begin
            if (32'(gap_q) < GAP_CYCLES) gap_d = gap_q + 1'b1;
            // Both the minimum gap and a released END are needed before the next GO.
            if ((32'(gap_q) + 32'd1 >= GAP_CYCLES) && !i2c_end) begin
               if (pend_q) begin
                  tcnt_d  = '0;
                  state_d = StGo;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy     = (state_q != StIdle);
   assign i2c_go   = (state_q == StGo);
   assign i2c_data = word_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         win_q   <= '0;
         word_q  <= '0;
         retry_q <= '0;
         pend_q  <= 1'b0;
         nack_q  <= 1'b0;
         tmo_q   <= 1'b0;
         gap_q   <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         word_q  <= word_d;
         retry_q <= retry_d;
         pend_q  <= pend_d;
         nack_q  <= nack_d;
         tmo_q   <= tmo_d;
         gap_q   <= gap_d;
         tcnt_q  <= tcnt_d;
      end
   end

endmodule

// File: tb/tb_wm8731_cfg_arbiter.sv
// Self-checking bench: vector table, randomized requests vs. a request-level model, corner cases.
module tb_wm8731_cfg_arbiter;
   import wm8731_cfg_pkg::*;

   localparam int N    = 4;
   localparam int GAP  = 16;
   localparam int TMO  = 200;
   localparam int MAXR = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [16*N-1:0] req_data = '0;
   logic [N-1:0]  req_ready, req_done, req_err;
   logic          busy, i2c_go;
   logic [23:0]   i2c_data;
   logic          i2c_end = 1'b0;
   logic          i2c_ack = 1'b0;

   wm8731_cfg_arbiter #(
      .N_REQ          (N),
      .SLAVE_ADDR     (8'h34),
      .MAX_RETRY      (MAXR),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .iCLK      (clk),
      .iRST_N    (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .req_done  (req_done),
      .req_err   (req_err),
      .busy      (busy),
      .i2c_data  (i2c_data),
      .i2c_go    (i2c_go),
      .i2c_end   (i2c_end),
      .i2c_ack   (i2c_ack)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   int ctl_delay = 1;
   int ctl_hold = 0;
   int nack_left = 0;
   bit ctl_never = 1'b0;

   int          rdy_q[$];
   int          done_q[$];
   int          err_q[$];
   logic [23:0] gdata_q[$];
   int          go_rises = 0;
   int          fall_cyc = 0;
   int          last_gap = 0;
   int          min_gap = 1000000;
   int          high_run = 0;
   int          last_high = 0;
   int          rdy_cyc = 0;
   int          rise_cyc = 0;
   bit          have_fall = 1'b0;
   bit          go_prev = 1'b0;
   logic [23:0] go_word = '0;

   int ptr_m = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int first_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int model_pick(input logic [N-1:0] mask);
      for (int k = 0; k < N; k++) if (mask[(ptr_m + k) % N]) return (ptr_m + k) % N;
      return -1;
   endfunction

   // Output monitor: pulse logs, GO pulse timing, word stability while GO is high.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            go_prev   = 1'b0;
            have_fall = 1'b0;
            high_run  = 0;
         end else begin
            if (req_ready != '0) begin
               if (!$onehot(req_ready)) begin
                  fails++;
                  $display("FAIL ready_onehot: got %b", req_ready);
               end
               rdy_q.push_back(first_idx(req_ready));
               rdy_cyc = cyc;
            end
            if (req_done != '0) begin
               if (!$onehot(req_done)) begin
                  fails++;
                  $display("FAIL done_onehot: got %b", req_done);
               end
               done_q.push_back(first_idx(req_done));
            end
            if (req_err != '0) begin
               if (!$onehot(req_err)) begin
                  fails++;
                  $display("FAIL err_onehot: got %b", req_err);
               end
               err_q.push_back(first_idx(req_err));
            end
            if ((req_done != '0) && (req_err != '0)) begin
               fails++;
               $display("FAIL done_and_err: done %b err %b", req_done, req_err);
            end
            if (i2c_go) begin
               if (!go_prev) begin
                  go_rises++;
                  rise_cyc = cyc;
                  go_word = i2c_data;
                  gdata_q.push_back(i2c_data);
                  if (have_fall) begin
                     last_gap = cyc - fall_cyc;
                     if (last_gap < min_gap) min_gap = last_gap;
                  end
                  high_run = 0;
               end else if (i2c_data !== go_word) begin
                  fails++;
                  $display("FAIL data_stable: got %h, required %h", i2c_data, go_word);
               end
               high_run++;
            end else if (go_prev) begin
               fall_cyc  = cyc;
               have_fall = 1'b1;
               last_high = high_run;
            end
            go_prev = i2c_go;
         end
      end
   end

   // I2C controller model: END after ctl_delay GO cycles, ACK unless NACKs are queued.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && i2c_go && !ctl_never) begin
            repeat (ctl_delay - 1) @(negedge clk);
            i2c_ack = (nack_left > 0);
            if (nack_left > 0) nack_left--;
            i2c_end = 1'b1;
            @(negedge clk);
            repeat (ctl_hold) @(negedge clk);
            i2c_end = 1'b0;
            i2c_ack = 1'b0;
         end
      end
   end

   task automatic xfer(input logic [N-1:0] mask, input logic [16*N-1:0] slices, input int nacks,
                       input int delay, input int hold, input logic [23:0] exp_word,
                       output int win, output int outcome, output int res_idx, output int gos,
                       output int bad);
      int r0, d0, e0, g0, gr0, budget;
      budget = 0;
      while (busy && budget < 5000) begin
         tick();
         budget++;
      end
      if (busy) check("idle_wait", 0, 1);
      ctl_delay = delay;
      ctl_hold  = hold;
      nack_left = nacks;
      r0 = rdy_q.size();
      d0 = done_q.size();
      e0 = err_q.size();
      g0 = gdata_q.size();
      gr0 = go_rises;
      req_valid = mask;
      req_data  = slices;
      budget = 0;
      while (rdy_q.size() == r0 && budget < 100) begin
         tick();
         budget++;
      end
      req_valid = '0;
      win = (rdy_q.size() > r0) ? rdy_q[r0] : -1;
      budget = 0;
      while (done_q.size() == d0 && err_q.size() == e0 && budget < 20000) begin
         tick();
         budget++;
      end
      outcome = 0;
      res_idx = -1;
      if (done_q.size() > d0) begin
         outcome = 1;
         res_idx = done_q[d0];
      end else if (err_q.size() > e0) begin
         outcome = 2;
         res_idx = err_q[e0];
      end
      gos = go_rises - gr0;
      bad = 0;
      for (int k = g0; k < gdata_q.size(); k++) if (gdata_q[k] !== exp_word) bad++;
   endtask

   task automatic exercise(input string tag, input logic [N-1:0] mask, input logic [16*N-1:0] slices,
                           input int nacks, input int delay, input int hold, input int exp_win,
                           input int exp_outcome, input int exp_gos, input logic [23:0] exp_word);
      int win, outcome, res_idx, gos, bad;
      xfer(mask, slices, nacks, delay, hold, exp_word, win, outcome, res_idx, gos, bad);
      check({tag, "_win"}, win, exp_win);
      check({tag, "_outcome"}, outcome, exp_outcome);
      check({tag, "_result_idx"}, res_idx, exp_win);
      check({tag, "_go_count"}, gos, exp_gos);
      check({tag, "_bad_words"}, bad, 0);
      ptr_m = (exp_win + 1) % N;
   endtask

   task automatic reset_dut();
      tick();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      ptr_m = 0;
   endtask

   typedef struct {
      logic [N-1:0] mask;
      logic [15:0]  data;
      int           nacks;
      int           delay;
      int           exp_win;
      int           exp_outcome;
      int           exp_gos;
      logic [23:0]  exp_word;
   } vec_t;

   vec_t tv[7];

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [16*N-1:0] sl;
      logic [N-1:0]    m;
      int              n, w, budget, r0, d0, e0;

      tv[0] = '{4'b0001, build_word(RegPower, 9'h000), 0, 50, 0, 1, 1, 24'h340C00};
      tv[1] = '{4'b0100, build_word(RegActive, 9'h001), 3, 5, 2, 1, 4, 24'h341201};
      tv[2] = '{4'b0100, build_word(RegActive, 9'h001), 4, 5, 2, 2, 4, 24'h341201};
      tv[3] = '{4'b1001, build_word(RegLhpOut, 9'h079), 0, 3, 3, 1, 1, 24'h340479};
      tv[4] = '{4'b1010, build_word(RegSample, 9'h000), 2, 7, 1, 1, 3, 24'h341000};
      tv[5] = '{4'b0011, build_word(RegDaif, 9'h00A), 1, 2, 0, 1, 2, 24'h340E0A};
      tv[6] = '{4'b1111, build_word(RegReset, 9'h000), 5, 1, 1, 2, 4, 24'h341E00};

      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_go", i2c_go, 0);
      check("rst_data", i2c_data, 0);
      check("rst_ready", req_ready, 0);
      check("rst_done", req_done, 0);
      check("rst_err", req_err, 0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < N; i++) sl[16*i +: 16] = tv[v].mask[i] ? tv[v].data : 16'hDEAD;
         exercise($sformatf("vec%0d", v), tv[v].mask, sl, tv[v].nacks, tv[v].delay, 0,
                  tv[v].exp_win, tv[v].exp_outcome, tv[v].exp_gos, tv[v].exp_word);
         if (v == 0) begin
            check("grant_to_go", rise_cyc - rdy_cyc, 1);
            n = 0;
            while (busy && n < 100) begin
               tick();
               n++;
            end
            check("busy_low_after_gap", n, GAP + 1);
         end
      end

      for (int t = 0; t < 20; t++) begin
         m  = N'($urandom_range(1, (1 << N) - 1));
         sl = {$urandom, $urandom};
         n  = $urandom_range(0, 5);
         w  = model_pick(m);
         exercise($sformatf("rnd%0d", t), m, sl, n, $urandom_range(1, 30), 0, w,
                  (n <= MAXR) ? 1 : 2, (n <= MAXR) ? n + 1 : MAXR + 1,
                  {8'h34, sl[16*w +: 16]});
      end

      // All requesters held valid from reset: strict rotation.
      reset_dut();
      min_gap = 1000000;
      ctl_delay = 3;
      nack_left = 0;
      r0 = rdy_q.size();
      d0 = done_q.size();
      req_data  = {16'h0603, 16'h0602, 16'h0601, 16'h0600};
      req_valid = 4'b1111;
      budget = 0;
      while (rdy_q.size() < r0 + 5 && budget < 5000) begin
         tick();
         budget++;
      end
      req_valid = '0;
      budget = 0;
      while (done_q.size() < d0 + 5 && budget < 2000) begin
         tick();
         budget++;
      end
      check("rot_grant_count", rdy_q.size() - r0, 5);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rot_grant%0d", k), (rdy_q.size() > r0 + k) ? rdy_q[r0 + k] : -1, k % N);
      end
      check("rot_done_count", done_q.size() - d0, 5);
      check("rot_min_gap_ok", min_gap >= GAP, 1);
      ptr_m = 1;

      // Controller never ends: watchdog abort, error, no retry.
      ctl_never = 1'b1;
      w = model_pick(4'b0010);
      exercise("timeout", 4'b0010, {4{16'h0A5A}}, 0, 1, 0, w, 2, 1, 24'h340A5A);
      check("timeout_go_len", last_high, TMO);
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check("timeout_idle", busy, 0);

      // Reset while GO is high; pending valid re-arbitrated from pointer 0.
      r0 = rdy_q.size();
      req_data  = {16'h1333, 16'h1222, 16'h1111, 16'h1000};
      req_valid = 4'b0100;
      budget = 0;
      while (!i2c_go && budget < 200) begin
         tick();
         budget++;
      end
      check("rstmid_go_seen", i2c_go, 1);
      repeat (5) tick();
      req_valid = 4'b1100;
      d0 = done_q.size();
      e0 = err_q.size();
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_go", i2c_go, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_ready", req_ready, 0);
      check("rstmid_done", req_done, 0);
      check("rstmid_err", req_err, 0);
      check("rstmid_data", i2c_data, 0);
      repeat (3) tick();
      ctl_never = 1'b0;
      ctl_delay = 4;
      r0 = rdy_q.size();
      rst_n = 1'b1;
      ptr_m = 0;
      check("rstmid_no_pulses", (done_q.size() - d0) + (err_q.size() - e0), 0);
      budget = 0;
      while (rdy_q.size() == r0 && budget < 100) begin
         tick();
         budget++;
      end
      req_valid = '0;
      w = model_pick(4'b1100);
      check("rstmid_regrant", (rdy_q.size() > r0) ? rdy_q[r0] : -1, w);
      budget = 0;
      while (done_q.size() == d0 && budget < 2000) begin
         tick();
         budget++;
      end
      check("rstmid_done_idx", (done_q.size() > d0) ? done_q[d0] : -1, w);
      ptr_m = (w + 1) % N;

      // END held high well past GAP: retry GO waits for END to clear.
      w = model_pick(4'b0001);
      exercise("endhold", 4'b0001, {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0817}, 1, 4, 40, w, 1, 2,
               24'h340817);
      check("endhold_gap_ok", last_gap > 40, 1);
      ctl_hold = 0;
      repeat (80) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
